// File: rtl/hex_display_pkg.sv
// Shared widths, blank pattern and active-low seven-segment encodings for the HEX display controller.
package hex_display_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Active-low pattern, bit6=g .. bit0=a.
  function automatic logic [SEG_W-1:0] seg_encode(input logic [DIGIT_W-1:0] digit);
    logic [SEG_W-1:0] seg;
    case (digit)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// One hex digit to active-low seven-segment pattern, with a forced-blank override.
module hex_seg_decode
  import hex_display_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               blank,
  output logic [SEG_W-1:0]   seg_c
);

  assign seg_c = blank ? SEG_BLANK : seg_encode(digit);

endmodule

// File: rtl/hex_display_ctrl.sv
// N-digit registered HEX display controller: load/count value register, leading-zero
// blanking and whole-display blink, driving active-low segment outputs.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned BLINK_DIV  = 25000000,
  parameter int unsigned TICK_DIV   = 50000000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] din,
  input  logic                          count_en,
  input  logic                          blink_en,
  input  logic                          lz_blank,
  output logic [DIGIT_W*NUM_DIGITS-1:0] value,
  output logic [SEG_W*NUM_DIGITS-1:0]   hex_out
);

  localparam int unsigned VAL_W   = DIGIT_W * NUM_DIGITS;
  localparam int unsigned HEX_W   = SEG_W * NUM_DIGITS;
  localparam int unsigned TICK_W  = $clog2(TICK_DIV);
  localparam int unsigned BLINK_W = $clog2(BLINK_DIV);

  logic [TICK_W-1:0]  tick_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               phase;

  logic               tick_wrap_c;
  logic               blink_wrap_c;
  logic               blank_all_c;
  logic [HEX_W-1:0]   seg_c;

  assign tick_wrap_c  = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign blink_wrap_c = (blink_cnt == BLINK_W'(BLINK_DIV - 1));
  // Dropping blink_en reveals the display on the very next edge.
  assign blank_all_c  = phase & blink_en;

  // Per-digit decode; digit k>0 blanks when it and every higher digit are zero.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic dig_blank;
    if (k == 0) begin : g_lsd
      assign dig_blank = blank_all_c;
    end else begin : g_upper
      assign dig_blank = blank_all_c | (lz_blank & ~|value[VAL_W-1:DIGIT_W*k]);
    end

    hex_seg_decode u_dec (
      .digit (value[DIGIT_W*k +: DIGIT_W]),
      .blank (dig_blank),
      .seg_c (seg_c[SEG_W*k +: SEG_W])
    );
  end

  // Value register, tick divider, blink divider and registered segment outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      value     <= '0;
      tick_cnt  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      hex_out   <= '1;
    end else begin
      if (load) begin
        value    <= din;
        tick_cnt <= '0;
      end else if (count_en) begin
        if (tick_wrap_c) begin
          tick_cnt <= '0;
          value    <= value + VAL_W'(1);
        end else begin
          tick_cnt <= tick_cnt + TICK_W'(1);
        end
      end

      if (!blink_en) begin
        blink_cnt <= '0;
        phase     <= 1'b0;
      end else if (blink_wrap_c) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end

      hex_out <= seg_c;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl (2 digits, fast dividers): vector table,
// directed count/blink/reset sequences and random stimulus against a reference model.
module tb_hex_display_ctrl;

  localparam int ND = 2;
  localparam int BD = 4;
  localparam int TD = 3;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clock = 1'b0;
  logic        reset, load, count_en, blink_en, lz_blank;
  logic [7:0]  din;
  logic [7:0]  value;
  logic [13:0] hex_out;

  int total = 0;
  int bad   = 0;

  // Reference model state: plain integers and elapsed-cycle ages.
  int          m_value;
  int          m_tick_age;
  int          m_blink_age;
  logic [13:0] m_hex;

  hex_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(BD), .TICK_DIV(TD)) dut (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .din      (din),
    .count_en (count_en),
    .blink_en (blink_en),
    .lz_blank (lz_blank),
    .value    (value),
    .hex_out  (hex_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ld;
    logic [7:0]  d;
    logic        lz;
    logic [7:0]  ev;
    logic [13:0] eh;
  } vec_t;

  vec_t tbl [8];

  localparam logic [13:0] HEX_00  = {7'b1000000, 7'b1000000};
  localparam logic [13:0] HEX_12  = {7'b1111001, 7'b0100100};
  localparam logic [13:0] HEX_ALL = 14'h3FFF;

  function automatic logic [13:0] exp_hex(input int v, input bit lz, input bit blank);
    logic [13:0] r;
    int d;
    int hi;
    r = '0;
    for (int k = 0; k < ND; k++) begin
      hi = v / (16 ** k);
      d  = hi % 16;
      if (blank || (lz && k > 0 && hi == 0)) r[7*k +: 7] = 7'h7F;
      else r[7*k +: 7] = SEG_TBL[d];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_edge();
    bit ph;
    if (reset) begin
      m_value = 0; m_tick_age = 0; m_blink_age = 0; m_hex = HEX_ALL;
    end else begin
      ph    = ((m_blink_age / BD) % 2) == 1;
      m_hex = exp_hex(m_value, lz_blank, blink_en && ph);
      if (load) begin
        m_value = int'(din); m_tick_age = 0;
      end else if (count_en) begin
        m_tick_age++;
        if (m_tick_age % TD == 0) m_value = (m_value + 1) % 256;
      end
      if (blink_en) m_blink_age++;
      else m_blink_age = 0;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    chk("model_value", 32'(value), 32'(m_value));
    chk("model_hex", 32'(hex_out), 32'(m_hex));
  endtask

  task automatic idle();
    reset = 0; load = 0; din = '0; count_en = 0; blink_en = 0; lz_blank = 0;
  endtask

  initial begin
    idle();
    m_value = 0; m_tick_age = 0; m_blink_age = 0; m_hex = HEX_ALL;

    // Reset and release.
    reset = 1;
    step(); step();
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_hex", 32'(hex_out), 32'(HEX_ALL));
    reset = 0;
    step();
    chk("release_hex_00", 32'(hex_out), 32'(HEX_00));

    // Vector table: hex_out always reflects the value of the previous cycle.
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 8'hA5, HEX_00};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 8'hA5, {7'b0001000, 7'b0010010}};
    tbl[2] = '{1'b1, 8'h07, 1'b1, 8'h07, {7'b0001000, 7'b0010010}};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 8'h07, {7'b1111111, 7'b1111000}};
    tbl[4] = '{1'b1, 8'h00, 1'b1, 8'h00, {7'b1111111, 7'b1111000}};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 8'h00, {7'b1111111, 7'b1000000}};
    tbl[6] = '{1'b1, 8'h12, 1'b0, 8'h12, HEX_00};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 8'h12, HEX_12};
    for (int i = 0; i < 8; i++) begin
      load = tbl[i].ld; din = tbl[i].d; lz_blank = tbl[i].lz;
      step();
      chk($sformatf("vec%0d_value", i), 32'(value), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_hex", i), 32'(hex_out), 32'(tbl[i].eh));
    end
    idle();

    // Counting across FE -> FF -> 00, then a load landing on a tick cycle.
    load = 1; din = 8'hFE;
    step();
    load = 0; count_en = 1;
    step(); step(); step();
    chk("count_fe_ff", 32'(value), 32'hFF);
    step(); step(); step();
    chk("count_wrap_00", 32'(value), 32'h00);
    step(); step();
    chk("count_hold_00", 32'(value), 32'h00);
    load = 1; din = 8'h3C;
    step();
    chk("load_on_tick", 32'(value), 32'h3C);
    load = 0;
    step();
    chk("load_tick_lost", 32'(value), 32'h3C);
    idle();

    // Blink: visible BD cycles, blank BD cycles; drop mid-blank, re-enable starts visible.
    load = 1; din = 8'h12;
    step();
    load = 0;
    step();
    blink_en = 1;
    for (int i = 0; i < 14; i++) begin
      step();
      chk($sformatf("blink_%0d", i), 32'(hex_out),
          ((i / BD) % 2 == 1) ? 32'(HEX_ALL) : 32'(HEX_12));
    end
    blink_en = 0;
    step();
    chk("blink_drop_visible", 32'(hex_out), 32'(HEX_12));
    blink_en = 1;
    for (int i = 0; i < BD; i++) begin
      step();
      chk($sformatf("reblink_vis_%0d", i), 32'(hex_out), 32'(HEX_12));
    end
    step();
    chk("reblink_blank", 32'(hex_out), 32'(HEX_ALL));

    // Reset in the middle of counting and blinking.
    count_en = 1;
    for (int i = 0; i < 2; i++) step();
    reset = 1;
    step();
    chk("midrst_value", 32'(value), 32'h0);
    chk("midrst_hex", 32'(hex_out), 32'(HEX_ALL));
    reset = 0; count_en = 0;
    step();
    chk("midrst_release_hex", 32'(hex_out), 32'(HEX_00));
    idle();

    // Random stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 49) == 0);
      load     = ($urandom_range(0, 7) == 0);
      din      = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) din = 8'($urandom_range(0, 15));
      count_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) blink_en = ~blink_en;
      lz_blank = 1'($urandom_range(0, 1));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
